stream_pipe_v: RTL and testbench

Forward-registered stream pipeline of configurable depth: `out_valid` and `out_data` come straight from flops, and `in_ready` is combinational from `out_ready` and stage occupancy. It complements `stream_buf_r`, which registers the ready path. Use it to break long valid/data paths between stream blocks, or to add matched latency. It provides collapsing bubbles and full one-item-per-cycle throughput.

---
 rtl/stream_pipe_v_pkg.sv | 21 ++
 rtl/stream_stage_v.sv | 45 ++++
 rtl/stream_pipe_v.sv | 94 +++++++++
 tb/tb_stream_pipe_v.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pipe_v_pkg.sv
// ============================================================================
// Module   : stream_pipe_v_pkg
// Brief    : Stream width constants and the occupancy-counter sizing rule.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_pipe_v_pkg;

    localparam int c_DEF_DATA_BITS  = 8;
    localparam int c_DEF_STAGES     = 2;
    localparam int c_DEF_COUNT_BITS = 2;

    // Counter must represent 0..stages inclusive.
    function automatic int min_count_bits(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_stage_v.sv
// ============================================================================
// Module   : stream_stage_v
// Brief    : One forward-registered stream stage: valid/data flops plus take.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_stage_v
    import stream_pipe_v_pkg::*;
#(
    parameter int DataBits = c_DEF_DATA_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                up_valid,
    input  logic [DataBits-1:0] up_data,
    input  logic                down_take,
    output logic                take,
    output logic                valid,
    output logic [DataBits-1:0] data
);

    logic                r_valid;
    logic [DataBits-1:0] r_data;

    // Empty stages always load, which is what collapses bubbles under stall.
    assign take  = ~r_valid | down_take;
    assign valid = r_valid;
    assign data  = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (take) begin
            r_valid <= up_valid;
            if (up_valid) begin
                r_data <= up_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/stream_pipe_v.sv
// ============================================================================
// Module   : stream_pipe_v
// Brief    : Forward-registered stream pipeline of Stages stages with occupancy.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_pipe_v
    import stream_pipe_v_pkg::*;
#(
    parameter int DataBits  = c_DEF_DATA_BITS,
    parameter int Stages    = c_DEF_STAGES,
    parameter int CountBits = c_DEF_COUNT_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DataBits-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DataBits-1:0]  out_data,
    output logic [CountBits-1:0] occupancy
);

    generate
        if (Stages < 1 || CountBits < min_count_bits(Stages)) begin : g_bad_params
            $error("stream_pipe_v: Stages must be >= 1 and 2**CountBits > Stages");
        end
    endgenerate

    logic [Stages-1:0]               w_valid;
    logic [Stages-1:0]               w_take;
    logic [Stages-1:0][DataBits-1:0] w_data;
    logic                            w_push;
    logic                            w_pop;
    logic [CountBits-1:0]            r_occupancy;

    generate
        for (genvar i = 0; i < Stages; i++) begin : g_stage
            logic                w_up_valid;
            logic [DataBits-1:0] w_up_data;
            logic                w_down_take;

            if (i == 0) begin : g_first
                assign w_up_valid = in_valid;
                assign w_up_data  = in_data;
            end else begin : g_inner
                assign w_up_valid = w_valid[i-1];
                assign w_up_data  = w_data[i-1];
            end

            if (i == Stages - 1) begin : g_last
                assign w_down_take = out_ready;
            end else begin : g_mid
                assign w_down_take = w_take[i+1];
            end

            stream_stage_v #(
                .DataBits (DataBits)
            ) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .up_valid  (w_up_valid),
                .up_data   (w_up_data),
                .down_take (w_down_take),
                .take      (w_take[i]),
                .valid     (w_valid[i]),
                .data      (w_data[i])
            );
        end
    endgenerate

    assign in_ready  = w_take[0];
    assign out_valid = w_valid[Stages-1];
    assign out_data  = w_data[Stages-1];
    assign occupancy = r_occupancy;

    assign w_push = in_valid & w_take[0];
    assign w_pop  = w_valid[Stages-1] & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occupancy <= '0;
        end else if (w_push & ~w_pop) begin
            r_occupancy <= r_occupancy + CountBits'(1);
        end else if (~w_push & w_pop) begin
            r_occupancy <= r_occupancy - CountBits'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stream_pipe_v.sv
// ============================================================================
// Module   : tb_stream_pipe_v
// Brief    : Directed and scoreboard checks on stream_pipe_v, Stages = 1..4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_pipe_v;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            out_ready;
    logic [3:0][7:0] in_data;
    logic [3:0][7:0] out_data;
    logic [3:0]      in_ready;
    logic [3:0]      out_valid;
    logic [3:0][2:0] occ;

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance k has Stages = k+1.
    generate
        for (genvar k = 0; k < 4; k++) begin : g_dut
            stream_pipe_v #(
                .DataBits  (8),
                .Stages    (k + 1),
                .CountBits (3)
            ) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid),
                .in_ready  (in_ready[k]),
                .in_data   (in_data[k]),
                .out_valid (out_valid[k]),
                .out_ready (out_ready),
                .out_data  (out_data[k]),
                .occupancy (occ[k])
            );
        end
    endgenerate

    task automatic set_data(input logic [7:0] v);
        for (int k = 0; k < 4; k++) in_data[k] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        set_data(8'h00);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        set_data(8'h00);
        #3;
        checks++;
        if (out_valid[1] !== 1'b0 || out_data[1] !== 8'h00 || occ[1] !== 3'd0 || in_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL reset_init: valid=%b data=%h occ=%0d ready=%b required 0/00/0/1",
                     out_valid[1], out_data[1], occ[1], in_ready[1]);
        end
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1;
        set_data(8'h11);
        tick();
        set_data(8'h22);
        tick();
        in_valid = 1'b0;
        checks++;
        if (occ[1] !== 3'd2 || out_valid[1] !== 1'b1) begin
            errors++;
            $display("FAIL reset_prefill: occ=%0d valid=%b required 2/1", occ[1], out_valid[1]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid[1] !== 1'b0 || out_data[1] !== 8'h00 || occ[1] !== 3'd0 || in_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL reset_async: valid=%b data=%h occ=%0d ready=%b required 0/00/0/1",
                     out_valid[1], out_data[1], occ[1], in_ready[1]);
        end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (out_valid[1] !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_reappear: cycle %0d valid=%b required 0", c, out_valid[1]);
            end
        end
    endtask

    task automatic test_latency_throughput();
        logic exp_v;
        do_reset();
        out_ready = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            in_valid = (e <= 16);
            set_data(8'(e));
            #1;
            if (e <= 16) begin
                checks++;
                if (in_ready[2] !== 1'b1) begin
                    errors++;
                    $display("FAIL lat_in_ready: edge %0d ready=%b required 1", e, in_ready[2]);
                end
            end
            tick();
            exp_v = (e >= 3 && e <= 18);
            checks++;
            if (out_valid[2] !== exp_v || (exp_v && out_data[2] !== 8'(e - 2))) begin
                errors++;
                $display("FAIL lat_out: after edge %0d valid=%b data=%h required %b/%h",
                         e, out_valid[2], out_data[2], exp_v, 8'(e - 2));
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_fill_stall();
        int acc;
        do_reset();
        acc = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 8 && acc < 4; c++) begin
            set_data(8'(8'hA1 + acc));
            #1;
            if (!in_ready[2]) break;
            tick();
            acc++;
        end
        checks++;
        if (acc != 3 || occ[2] !== 3'd3 || in_ready[2] !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: accepts=%0d occ=%0d ready=%b required 3/3/0", acc, occ[2], in_ready[2]);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_valid = (acc < 4);
            set_data(8'(8'hA1 + acc));
            #1;
            checks++;
            if (out_valid[2] !== 1'b1 || out_data[2] !== 8'(8'hA1 + c)) begin
                errors++;
                $display("FAIL fill_drain: slot %0d valid=%b data=%h required 1/%h",
                         c, out_valid[2], out_data[2], 8'(8'hA1 + c));
            end
            if (in_valid && in_ready[2]) acc++;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid[2] !== 1'b0 || occ[2] !== 3'd0 || acc != 4) begin
            errors++;
            $display("FAIL fill_empty: valid=%b occ=%0d accepts=%0d required 0/0/4", out_valid[2], occ[2], acc);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        in_valid = 1'b1;
        set_data(8'h31);
        tick();
        set_data(8'h32);
        tick();
        set_data(8'h33);
        #1;
        checks++;
        if (occ[1] !== 3'd2 || in_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full: occ=%0d ready=%b required 2/0", occ[1], in_ready[1]);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            set_data(8'(8'h33 + c));
            #1;
            checks++;
            if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b1 || out_data[1] !== 8'(8'h31 + c)) begin
                errors++;
                $display("FAIL b2b_swap: cycle %0d ready=%b valid=%b data=%h required 1/1/%h",
                         c, in_ready[1], out_valid[1], out_data[1], 8'(8'h31 + c));
            end
            tick();
            checks++;
            if (occ[1] !== 3'd2) begin
                errors++;
                $display("FAIL b2b_occ: cycle %0d occ=%0d required 2", c, occ[1]);
            end
        end
        in_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (out_valid[1] !== 1'b1 || out_data[1] !== 8'(8'h36 + c)) begin
                errors++;
                $display("FAIL b2b_drain: slot %0d valid=%b data=%h required 1/%h",
                         c, out_valid[1], out_data[1], 8'(8'h36 + c));
            end
            tick();
        end
    endtask

    task automatic test_stall();
        do_reset();
        in_valid = 1'b1;
        set_data(8'h5A);
        tick();
        in_valid = 1'b0;
        tick();
        for (int c = 0; c < 10; c++) begin
            set_data(8'($urandom));
            #1;
            checks++;
            if (out_valid[1] !== 1'b1 || out_data[1] !== 8'h5A) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d valid=%b data=%h required 1/5a", c, out_valid[1], out_data[1]);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [7:0] seq  [4];
        logic [7:0] ring [4][16];
        int         head [4];
        int         cnt  [4];
        logic       exp_ready;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            seq[k] = 8'h00;
            head[k] = 0;
            cnt[k] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) in_data[k] = seq[k];
            #1;
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (occ[k] !== 3'(cnt[k]) || cnt[k] > k + 1) begin
                    errors++;
                    $display("FAIL rand_occ: S=%0d cycle %0d occ=%0d required %0d", k + 1, c, occ[k], cnt[k]);
                end
                exp_ready = (cnt[k] < k + 1) || out_ready;
                checks++;
                if (in_ready[k] !== exp_ready) begin
                    errors++;
                    $display("FAIL rand_ready: S=%0d cycle %0d ready=%b required %b", k + 1, c, in_ready[k], exp_ready);
                end
                if (out_valid[k] && out_ready) begin
                    checks++;
                    if (cnt[k] == 0 || out_data[k] !== ring[k][head[k]]) begin
                        errors++;
                        $display("FAIL rand_order: S=%0d cycle %0d data=%h required %h depth=%0d",
                                 k + 1, c, out_data[k], ring[k][head[k]], cnt[k]);
                    end
                    if (cnt[k] > 0) begin
                        head[k] = (head[k] + 1) % 16;
                        cnt[k]--;
                    end
                end else if (cnt[k] == 0) begin
                    checks++;
                    if (out_valid[k] !== 1'b0) begin
                        errors++;
                        $display("FAIL rand_empty: S=%0d cycle %0d valid=%b required 0", k + 1, c, out_valid[k]);
                    end
                end
                if (in_valid && in_ready[k]) begin
                    ring[k][(head[k] + cnt[k]) % 16] = seq[k];
                    cnt[k]++;
                    seq[k] = seq[k] + 8'd1;
                end
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency_throughput();
        test_fill_stall();
        test_back_to_back();
        test_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
